// File: rtl/link16_dsp_if_pkg.sv
// Shared constants and types for the DSP-to-link16 SPI header path.
// Sizes, reset defaults and the header read FSM encoding live here.
package link16_dsp_if_pkg;

    localparam int HDR_WORDS           = 8;
    localparam int DATA_W              = 32;
    localparam int ADDR_W              = 4;
    localparam int IDX_W               = 3;
    localparam int GAP_TIMEOUT_DEFAULT = 4096;

    localparam logic [6:0]        SPI_LEN_DEFAULT = 7'd31;
    localparam logic [DATA_W-1:0] HDR_SYNC_WORD   = 32'h5555AAAA;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(HDR_WORDS - 1);
    endfunction

endpackage

// File: rtl/spi_rtt_hdr_pingpong.sv
// Two-bank header store with per-bank ready flags and independent
// write/read bank pointers; the controller decides when to commit or release.
module spi_rtt_hdr_pingpong
    import link16_dsp_if_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic [IDX_W-1:0]  rd_addr,
    input  logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        ready,
    output logic              wbank,
    output logic              rbank
);

    logic [DATA_W-1:0] mem [2][HDR_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wbank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rbank][rd_addr];

    // Commit and release never target the same bank: a bank is only committed while free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (commit) begin
                ready[wbank] <= 1'b1;
                wbank        <= ~wbank;
            end
            if (rd_done) begin
                ready[rbank] <= 1'b0;
                rbank        <= ~rbank;
            end
        end
    end

endmodule

// File: rtl/spi_rtt_hdr_ctrl.sv
// RTT header controller: collects SPI header frames into the ping-pong store,
// checks order and gaps, and streams one frame per RTT slot to the transmitter.
module spi_rtt_hdr_ctrl
    import link16_dsp_if_pkg::*;
#(
    parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEFAULT
)
(
    input  logic              logic_clk_in,
    input  logic              logic_rst_in,
    input  logic [6:0]        cfg_spi_len_in,
    input  logic              cfg_spi_len_wr_in,
    output logic [6:0]        spi_reg_length_out,
    input  logic              spi_wr_in,
    input  logic [ADDR_W-1:0] spi_wr_addr_in,
    input  logic [DATA_W-1:0] spi_wr_data_in,
    input  logic              rtt_slot_start_in,
    output logic [DATA_W-1:0] rtt_hdr_data_out,
    output logic [2:0]        rtt_hdr_idx_out,
    output logic              rtt_hdr_valid_out,
    input  logic              rtt_hdr_ready_in,
    output logic              rtt_hdr_last_out,
    output logic              rtt_hdr_miss_out,
    output logic              hdr_seq_err_out,
    output logic              hdr_ovf_out,
    output logic [1:0]        bank_ready_out
);

    localparam int               GAP_W     = $clog2(GAP_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(HDR_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT - 1);

    rd_state_e         state_q, state_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [IDX_W-1:0]  wcnt_q, wcnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              lost_q, lost_d;
    logic              seq_err_d, ovf_d, miss_d;
    logic              mem_wr_en, commit, rd_done;
    logic              in_order, wbank_busy;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        bank_ready;
    logic              wbank, rbank;

    spi_rtt_hdr_pingpong u_pingpong (
        .clk     (logic_clk_in),
        .rst     (logic_rst_in),
        .wr_en   (mem_wr_en),
        .wr_addr (spi_wr_addr_in[IDX_W-1:0]),
        .wr_data (spi_wr_data_in),
        .commit  (commit),
        .rd_addr (ridx_q),
        .rd_done (rd_done),
        .rd_data (rd_data),
        .ready   (bank_ready),
        .wbank   (wbank),
        .rbank   (rbank)
    );

    assign in_order       = (spi_wr_addr_in == ADDR_W'(wcnt_q));
    assign wbank_busy     = bank_ready[wbank] || ((state_q == RD_SEND) && (rbank == wbank));
    assign bank_ready_out = bank_ready;

    // A frame whose target bank was busy for any word is flagged lost and dropped at completion.
    always_comb begin
        wcnt_d    = wcnt_q;
        gap_d     = gap_q;
        lost_d    = lost_q;
        seq_err_d = 1'b0;
        ovf_d     = 1'b0;
        mem_wr_en = 1'b0;
        commit    = 1'b0;
        if (cfg_spi_len_wr_in && (wcnt_q != '0)) begin
            wcnt_d    = '0;
            gap_d     = '0;
            lost_d    = 1'b0;
            seq_err_d = 1'b1;
        end else if (spi_wr_in) begin
            gap_d = '0;
            if (in_order) begin
                mem_wr_en = !wbank_busy;
                if (wcnt_q == LAST_IDX) begin
                    wcnt_d = '0;
                    lost_d = 1'b0;
                    if (wbank_busy || lost_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                    lost_d = lost_q || wbank_busy;
                end
            end else begin
                seq_err_d = 1'b1;
                if (spi_wr_addr_in == '0) begin
                    mem_wr_en = !wbank_busy;
                    wcnt_d    = IDX_W'(1);
                    lost_d    = wbank_busy;
                end else begin
                    wcnt_d = '0;
                    lost_d = 1'b0;
                end
            end
        end else if (wcnt_q != '0) begin
            if (gap_q == GAP_LIMIT) begin
                wcnt_d    = '0;
                gap_d     = '0;
                lost_d    = 1'b0;
                seq_err_d = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            wcnt_q             <= '0;
            gap_q              <= '0;
            lost_q             <= 1'b0;
            hdr_seq_err_out    <= 1'b0;
            hdr_ovf_out        <= 1'b0;
            rtt_hdr_miss_out   <= 1'b0;
            spi_reg_length_out <= SPI_LEN_DEFAULT;
        end else begin
            wcnt_q           <= wcnt_d;
            gap_q            <= gap_d;
            lost_q           <= lost_d;
            hdr_seq_err_out  <= seq_err_d;
            hdr_ovf_out      <= ovf_d;
            rtt_hdr_miss_out <= miss_d;
            if (cfg_spi_len_wr_in) begin
                spi_reg_length_out <= cfg_spi_len_in;
            end
        end
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            state_q <= RD_IDLE;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            ridx_q  <= ridx_d;
        end
    end

    // Slot starts during SEND are dropped silently; the ready flag is sampled registered,
    // so a bank committed on the slot-start cycle still counts as a miss.
    always_comb begin
        state_d = state_q;
        ridx_d  = ridx_q;
        miss_d  = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rtt_slot_start_in) begin
                    if (bank_ready[rbank]) begin
                        state_d = RD_SEND;
                        ridx_d  = '0;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
            end
            RD_SEND: begin
                if (rtt_hdr_ready_in) begin
                    if (is_last_idx(ridx_q)) begin
                        ridx_d  = '0;
                        rd_done = 1'b1;
                        state_d = RD_IDLE;
                    end else begin
                        ridx_d = ridx_q + 1'b1;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rtt_hdr_valid_out = 1'b0;
        rtt_hdr_data_out  = '0;
        rtt_hdr_idx_out   = '0;
        rtt_hdr_last_out  = 1'b0;
        if (state_q == RD_SEND) begin
            rtt_hdr_valid_out = 1'b1;
            rtt_hdr_data_out  = rd_data;
            rtt_hdr_idx_out   = ridx_q;
            rtt_hdr_last_out  = is_last_idx(ridx_q);
        end
    end

endmodule

// File: tb/tb_spi_rtt_hdr_ctrl.sv
// Self-checking bench for spi_rtt_hdr_ctrl: scoreboard of expected header beats
// plus table-driven write/config vectors and hand-written corner sequences.
module tb_spi_rtt_hdr_ctrl;
    import link16_dsp_if_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [2:0]        idx;
        logic              last;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              exp_err;
        logic              exp_commit;
        logic              push;
    } wr_vec_t;

    typedef struct {
        logic [6:0] len;
        logic [6:0] exp_len;
    } cfg_vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        cfg_len = '0;
    logic              cfg_wr = 1'b0;
    logic [6:0]        spi_len;
    logic              spi_wr = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              slot = 1'b0;
    logic [DATA_W-1:0] hdr_data;
    logic [2:0]        hdr_idx;
    logic              hdr_valid;
    logic              hdr_ready = 1'b1;
    logic              hdr_last;
    logic              hdr_miss;
    logic              seq_err;
    logic              ovf;
    logic [1:0]        bank_ready;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    seq_err_cnt = 0;
    int    ovf_cnt = 0;
    int    miss_cnt = 0;
    logic  model_wbank = 1'b0;

    always #5 clk = ~clk;

    spi_rtt_hdr_ctrl dut (
        .logic_clk_in       (clk),
        .logic_rst_in       (rst),
        .cfg_spi_len_in     (cfg_len),
        .cfg_spi_len_wr_in  (cfg_wr),
        .spi_reg_length_out (spi_len),
        .spi_wr_in          (spi_wr),
        .spi_wr_addr_in     (wr_addr),
        .spi_wr_data_in     (wr_data),
        .rtt_slot_start_in  (slot),
        .rtt_hdr_data_out   (hdr_data),
        .rtt_hdr_idx_out    (hdr_idx),
        .rtt_hdr_valid_out  (hdr_valid),
        .rtt_hdr_ready_in   (hdr_ready),
        .rtt_hdr_last_out   (hdr_last),
        .rtt_hdr_miss_out   (hdr_miss),
        .hdr_seq_err_out    (seq_err),
        .hdr_ovf_out        (ovf),
        .bank_ready_out     (bank_ready)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                 input logic slot_start, input logic cfg_load, input logic [6:0] len);
        @(posedge clk);
        #1;
        spi_wr  = wr;
        wr_addr = addr;
        wr_data = data;
        slot    = slot_start;
        cfg_wr  = cfg_load;
        cfg_len = len;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic slotStart();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic writeFrame(input logic [DATA_W-1:0] base, input bit push);
        for (int i = 0; i < HDR_WORDS; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), base + DATA_W'(i), 1'b0, 1'b0, '0);
            if (push) exp_q.push_back('{data: base + DATA_W'(i), idx: 3'(i), last: (i == HDR_WORDS - 1)});
        end
        idleCycle();
    endtask

    task automatic waitQueue(input int target, input int bound, input string name);
        int n = 0;
        while (exp_q.size() > target && n < bound) begin
            idleCycle();
            n++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'(target));
    endtask

    // Every valid cycle must present the oldest outstanding beat; acceptance retires it.
    always @(negedge clk) begin
        if (!rst) begin
            if (seq_err) seq_err_cnt++;
            if (ovf) ovf_cnt++;
            if (hdr_miss) miss_cnt++;
            if (hdr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got idx %0d data %0h, expected no beat", hdr_idx, hdr_data);
                end else begin
                    checkOutput("beat_data", 64'(hdr_data), 64'(exp_q[0].data));
                    checkOutput("beat_idx", 64'(hdr_idx), 64'(exp_q[0].idx));
                    checkOutput("beat_last", 64'(hdr_last), 64'(exp_q[0].last));
                    if (hdr_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_vec_t  wr_vecs[11];
        cfg_vec_t cfg_vecs[5];
        logic [3:0] pat;
        logic [6:0] prev_len;
        int e0, s0, m0, n;
        bit found;

        wr_vecs[0]  = '{4'd0, 32'hE0, 1'b0, 1'b0, 1'b0};
        wr_vecs[1]  = '{4'd1, 32'hE1, 1'b0, 1'b0, 1'b0};
        wr_vecs[2]  = '{4'd3, 32'hE3, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < HDR_WORDS; i++)
            wr_vecs[3+i] = '{ADDR_W'(i), 32'hF0 + DATA_W'(i), 1'b0, (i == HDR_WORDS - 1), 1'b1};
        cfg_vecs[0] = '{7'd15, 7'd15};
        cfg_vecs[1] = '{7'd0, 7'd0};
        cfg_vecs[2] = '{7'd127, 7'd127};
        cfg_vecs[3] = '{7'd64, 7'd64};
        cfg_vecs[4] = '{7'd31, 7'd31};
        pat = 4'b1001;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(hdr_valid), 64'd0);
        checkOutput("rst_spi_len", 64'(spi_len), 64'd31);
        checkOutput("rst_bank_ready", 64'(bank_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycle();
        checkOutput("post_rst_spi_len", 64'(spi_len), 64'd31);
        checkOutput("post_rst_pulses", 64'({hdr_miss, seq_err, ovf}), 64'd0);
        checkOutput("post_rst_data", 64'(hdr_data), 64'd0);

        // Single frame delivered on one slot
        writeFrame(32'hA0, 1'b1);
        checkOutput("t1_bank_ready", 64'(bank_ready), 64'(2'(2'b01 << model_wbank)));
        model_wbank ^= 1'b1;
        slotStart();
        idleCycle();
        checkOutput("t1_first_beat_latency", 64'(hdr_valid), 64'd1);
        waitQueue(0, 40, "t1_drain");
        idleCycle();
        checkOutput("t1_bank_ready_after", 64'(bank_ready), 64'd0);
        checkOutput("t1_valid_after", 64'(hdr_valid), 64'd0);

        // Third frame with both banks full is dropped
        e0 = ovf_cnt;
        s0 = seq_err_cnt;
        writeFrame(32'hB0, 1'b1);
        model_wbank ^= 1'b1;
        writeFrame(32'hC0, 1'b1);
        model_wbank ^= 1'b1;
        writeFrame(32'hD0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t2_ovf_pulses", 64'(ovf_cnt - e0), 64'd1);
        checkOutput("t2_no_seq_err", 64'(seq_err_cnt - s0), 64'd0);
        checkOutput("t2_bank_ready", 64'(bank_ready), 64'd3);
        slotStart();
        waitQueue(8, 40, "t2_drain_b");
        slotStart();
        waitQueue(0, 40, "t2_drain_c");
        idleCycle();
        checkOutput("t2_bank_ready_after", 64'(bank_ready), 64'd0);

        // Out-of-order address then a clean frame
        foreach (wr_vecs[i]) begin
            applyStimulus(1'b1, wr_vecs[i].addr, wr_vecs[i].data, 1'b0, 1'b0, '0);
            if (wr_vecs[i].push)
                exp_q.push_back('{data: wr_vecs[i].data, idx: wr_vecs[i].addr[2:0], last: wr_vecs[i].exp_commit});
            idleCycle();
            checkOutput($sformatf("t3_seq_err_%0d", i), 64'(seq_err), 64'(wr_vecs[i].exp_err));
            checkOutput($sformatf("t3_bank_ready_%0d", i), 64'(bank_ready),
                        wr_vecs[i].exp_commit ? 64'(2'(2'b01 << model_wbank)) : 64'd0);
            if (wr_vecs[i].exp_commit) model_wbank ^= 1'b1;
        end
        slotStart();
        waitQueue(0, 40, "t3_drain");
        idleCycle();
        checkOutput("t3_bank_ready_after", 64'(bank_ready), 64'd0);

        // Partial frame abandoned by the gap timer
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, ADDR_W'(i), 32'h90 + DATA_W'(i), 1'b0, 1'b0, '0);
        idleCycle();
        found = 1'b0;
        n = 0;
        while (!found && n < GAP_TIMEOUT_DEFAULT + 50) begin
            idleCycle();
            n++;
            if (seq_err) found = 1'b1;
        end
        checkOutput("t4_timeout_seen", 64'(found), 64'd1);
        checkOutput("t4_timeout_window", 64'((n >= GAP_TIMEOUT_DEFAULT - 2) && (n <= GAP_TIMEOUT_DEFAULT + 2)), 64'd1);
        checkOutput("t4_bank_ready", 64'(bank_ready), 64'd0);
        m0 = miss_cnt;
        slotStart();
        idleCycle();
        checkOutput("t4_miss_pulse", 64'(hdr_miss), 64'd1);
        checkOutput("t4_no_valid", 64'(hdr_valid), 64'd0);
        idleCycle();
        checkOutput("t4_miss_count", 64'(miss_cnt - m0), 64'd1);

        // Backpressure with a second slot start mid-SEND
        writeFrame(32'h1234_5670, 1'b1);
        model_wbank ^= 1'b1;
        m0 = miss_cnt;
        slotStart();
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            hdr_ready = pat[c % 4];
            applyStimulus(1'b0, '0, '0, (c == 2), 1'b0, '0);
        end
        hdr_ready = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("t5_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("t5_no_miss", 64'(miss_cnt - m0), 64'd0);
        checkOutput("t5_valid_after", 64'(hdr_valid), 64'd0);

        // Config load while a frame is partial aborts it
        applyStimulus(1'b1, 4'd0, 32'h70, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd1, 32'h71, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 7'd15);
        checkOutput("t6_len_before_edge", 64'(spi_len), 64'd31);
        idleCycle();
        checkOutput("t6_abort_seq_err", 64'(seq_err), 64'd1);
        checkOutput("t6_len_loaded", 64'(spi_len), 64'd15);
        prev_len = 7'd15;
        foreach (cfg_vecs[i]) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, cfg_vecs[i].len);
            checkOutput($sformatf("t6_len_hold_%0d", i), 64'(spi_len), 64'(prev_len));
            idleCycle();
            checkOutput($sformatf("t6_len_%0d", i), 64'(spi_len), 64'(cfg_vecs[i].exp_len));
            prev_len = cfg_vecs[i].exp_len;
        end

        // Asynchronous reset in the middle of a SEND
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 7'd15);
        idleCycle();
        checkOutput("t7_len_15", 64'(spi_len), 64'd15);
        writeFrame(32'hCAFE_0000, 1'b1);
        slotStart();
        idleCycle();
        idleCycle();
        checkOutput("t7_in_send", 64'(hdr_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t7_rst_valid", 64'(hdr_valid), 64'd0);
        checkOutput("t7_rst_len", 64'(spi_len), 64'd31);
        checkOutput("t7_rst_bank_ready", 64'(bank_ready), 64'd0);
        exp_q.delete();
        model_wbank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) idleCycle();
        checkOutput("t7_post_rst_valid", 64'(hdr_valid), 64'd0);

        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
